led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 12500000: clk cycles per automatic LED step (>=2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000: cycles a synchronized button must stay high before it is accepted (>=1).
REQ-003 SHALL have port clk, input, 1: single system clock, all logic on its rising edge.
REQ-004 SHALL have port rst_in, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port switch, input, 8: load value for led.
REQ-006 SHALL have port mode, input, 2: 00 count up, 01 count down, 10 rotate left, 11 rotate right.
REQ-007 SHALL have port push_btn, input, 3, raw and asynchronous: [0] run/pause toggle, [1] single step, [2] load.
REQ-008 SHALL have port led, output, 8: registered LED pattern.
REQ-009 SHALL have port step_out, output, 1: registered one-cycle pulse, high in the first cycle led shows an advanced value.
REQ-010 SHALL have port state_out, output, 2: current FSM state (00 IDLE, 01 RUN, 10 PAUSE).

Function
REQ-011 Each push_btn bit SHALL pass a 2-flop synchronizer, then a debouncer that asserts a one-cycle press pulse when the synchronized level has been high for DEBOUNCE_CYCLES consecutive cycles after being low. Any low sample restarts the count.
REQ-012 A held button SHALL produce exactly one press pulse; a new pulse requires release, then a fresh stable-high period.
REQ-013 The FSM SHALL make these transitions on a run pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN. No other transitions exist besides reset.
REQ-014 In RUN, the prescaler SHALL count 0..CLK_DIV-1 and wrap; terminal count produces an advance in that cycle.
REQ-015 The prescaler SHALL be cleared to 0 whenever the state is not RUN and on every load pulse.
REQ-016 A step pulse SHALL produce one advance in IDLE or PAUSE and SHALL be ignored in RUN.
REQ-017 Advance SHALL update led at the clock edge ending the advance cycle, per the mode sampled in that cycle:
- up: led+1 mod 256 (FF->00).
- down: led-1 mod 256 (00->FF).
- rotate left: led[7] into bit 0.
- rotate right: led[0] into bit 7.
REQ-018 In either rotate mode, an advance with led==8'h00 SHALL load 8'h01.
REQ-019 A load pulse SHALL set led<=switch at the next edge in any state, leave the state unchanged, and assert no step_out.
REQ-020 Same-cycle priority SHALL be load > run toggle > advance. A suppressed advance is dropped, not deferred.
REQ-021 A run toggle and a terminal count in the same cycle SHALL change state with no advance.
REQ-022 A mode change SHALL take effect at the next advance and SHALL NOT reset the prescaler.
REQ-023 step_out SHALL be high exactly one cycle per advance; load and reset SHALL NOT pulse it.

Reset
REQ-024 While rst_in==0 at a rising edge, the block SHALL load: state IDLE, led 8'h00, step_out 0, prescaler 0, debounce counters 0, synchronizer flops 0.
REQ-025 A reset mid-count or mid-debounce SHALL discard all progress; a button held through reset release SHALL still need DEBOUNCE_CYCLES after release before its pulse.

Structure
REQ-026 Package led_seq_pkg SHALL hold the state encoding (IDLE/RUN/PAUSE), the mode encoding, and the button index constants (BTN_RUN=0, BTN_STEP=1, BTN_LOAD=2).
REQ-027 Sub-module btn_debounce (clk, rst_in, btn_raw, press_pulse; parameter DEBOUNCE_CYCLES) SHALL hold the synchronizer plus debouncer and SHALL be instantiated three times.
REQ-028 Counter widths SHALL be $clog2 of their parameter; no other sub-modules.

Verification (CLK_DIV=4, DEBOUNCE_CYCLES=3)
REQ-029 The bench SHALL cover:
- Reset, then idle: led 00, state_out 00, no step_out for 50 cycles.
- Run with mode=00: press btn0 for 10 cycles; led steps 00->01->02->03 every 4 cycles, one step_out per step.
- Bounce: glitch btn1 high 2 cycles, low 1, high 2; no pulse and led unchanged. Hold 6 cycles in PAUSE: exactly one advance.
- Boundary: load switch=FF in up mode, one step -> 00. Load 00 in down mode, step -> FF. Load 00 in rotate-left mode, step -> 01. Load 81 in rotate-right mode, step -> C0.
- Simultaneous: load and run pulse in the same cycle in RUN; led=switch, state stays RUN, prescaler restarts, next step 4 cycles later.
- Mid-run reset: rst_in low one cycle at prescaler=2; led 00, IDLE, no step_out afterward.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: FSM states, step modes, button indices
// and the pattern-advance function.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_ROL  = 2'b10,
        MODE_ROR  = 2'b11
    } mode_e;

    localparam int BTN_RUN  = 0;
    localparam int BTN_STEP = 1;
    localparam int BTN_LOAD = 2;

    // Rotating an all-zero pattern would stay dark forever, so it reseeds with bit 0.
    function automatic logic [7:0] next_led(input logic [7:0] cur, input mode_e m);
        logic [7:0] nxt;
        nxt = cur;
        case (m)
            MODE_UP:   nxt = cur + 8'd1;
            MODE_DOWN: nxt = cur - 8'd1;
            MODE_ROL:  nxt = (cur == 8'h00) ? 8'h01 : {cur[6:0], cur[7]};
            MODE_ROR:  nxt = (cur == 8'h00) ? 8'h01 : {cur[0], cur[7:1]};
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debouncer: one press_pulse per accepted press, after
// DEBOUNCE_CYCLES consecutive high samples following a low level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_in,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             fired_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fired_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            // NOTE: press_q defaults low every cycle, so it can only ever be a one-cycle pulse.
            press_q <= 1'b0;
            if (!sync2_q) begin
                cnt_q   <= '0;
                fired_q <= 1'b0;
            end else if (!fired_q) begin
                if (cnt_q == CNT_LAST) begin
                    press_q <= 1'b1;
                    fired_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign press_pulse = press_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: debounced run/step/load buttons drive an IDLE/RUN/PAUSE FSM that
// advances an 8-bit pattern on a prescaled tick (RUN) or on a manual step.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int CLK_DIV         = 12500000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic [7:0] switch,
    input  logic [1:0] mode,
    input  logic [2:0] push_btn,
    output logic [7:0] led,
    output logic       step_out,
    output logic [1:0] state_out
);

    localparam int PRE_W = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic run_p;
    logic step_p;
    logic load_p;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_run (
        .clk(clk), .rst_in(rst_in), .btn_raw(push_btn[BTN_RUN]), .press_pulse(run_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_step (
        .clk(clk), .rst_in(rst_in), .btn_raw(push_btn[BTN_STEP]), .press_pulse(step_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_load (
        .clk(clk), .rst_in(rst_in), .btn_raw(push_btn[BTN_LOAD]), .press_pulse(load_p)
    );

    state_e           state_q;
    logic [7:0]       led_q;
    logic             step_q;
    logic [PRE_W-1:0] presc_q;

    logic in_run;
    logic term_cnt;
    logic advance;

    // Load beats a run toggle, which beats an advance; losers are dropped outright.
    assign in_run   = (state_q == ST_RUN);
    assign term_cnt = in_run && (presc_q == PRE_LAST);
    assign advance  = !load_p && !run_p && (in_run ? term_cnt : step_p);

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            led_q   <= 8'h00;
            step_q  <= 1'b0;
            presc_q <= '0;
        end else begin
            step_q <= advance;

            if (!in_run || load_p || term_cnt) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PRE_W'(1);
            end

            if (load_p) begin
                led_q <= switch;
            end else if (advance) begin
                led_q <= next_led(led_q, mode_e'(mode));
            end

            if (run_p && !load_p) begin
                case (state_q)
                    ST_IDLE:  state_q <= ST_RUN;
                    ST_RUN:   state_q <= ST_PAUSE;
                    ST_PAUSE: state_q <= ST_RUN;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign led       = led_q;
    assign step_out  = step_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with CLK_DIV=4, DEBOUNCE_CYCLES=3: table of
// load/step boundary vectors plus hand-written run, bounce, priority and reset sequences.
module tb_led_seq_ctrl;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 3;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;

    logic       clk = 1'b0;
    logic       rst_in = 1'b0;
    logic [7:0] switch = 8'h00;
    logic [1:0] mode = 2'b00;
    logic [2:0] push_btn = 3'b000;
    logic [7:0] led;
    logic       step_out;
    logic [1:0] state_out;

    int errors   = 0;
    int checks   = 0;
    int step_cnt = 0;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] sw;
        logic [7:0] expect_led;
    } vec_t;

    led_seq_ctrl #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk),
        .rst_in(rst_in),
        .switch(switch),
        .mode(mode),
        .push_btn(push_btn),
        .led(led),
        .step_out(step_out),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step_out === 1'b1) step_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input int idx, input int hold);
        push_btn[idx] = 1'b1;
        repeat (hold) cyc();
        push_btn[idx] = 1'b0;
        repeat (8) cyc();
    endtask

    initial begin
        vec_t       vecs[6];
        int         c0;
        int         n;
        int         idx[3];
        logic [7:0] lv[3];
        logic [7:0] snap;
        int         load_k;
        int         next_k;
        logic [7:0] next_v;
        logic       step_at_load;
        int         found;

        vecs[0] = '{2'b00, 8'hFF, 8'h00};
        vecs[1] = '{2'b01, 8'h00, 8'hFF};
        vecs[2] = '{2'b10, 8'h00, 8'h01};
        vecs[3] = '{2'b10, 8'h80, 8'h01};
        vecs[4] = '{2'b11, 8'h01, 8'h80};
        vecs[5] = '{2'b11, 8'h81, 8'hC0};

        // Reset and idle
        repeat (3) cyc();
        check("reset_led", led, 8'h00);
        check("reset_state", state_out, S_IDLE);
        check("reset_step", step_out, 1'b0);
        rst_in = 1'b1;
        c0 = step_cnt;
        repeat (50) cyc();
        check("idle_steps", step_cnt - c0, 0);
        check("idle_led", led, 8'h00);
        check("idle_state", state_out, S_IDLE);

        // Run in up mode: button held 10 cycles gives a single toggle
        mode = 2'b00;
        n = 0;
        idx[0] = 0; idx[1] = 0; idx[2] = 0;
        lv[0] = 8'h00; lv[1] = 8'h00; lv[2] = 8'h00;
        push_btn[0] = 1'b1;
        for (int k = 1; k <= 40 && n < 3; k++) begin
            cyc();
            if (k == 10) push_btn[0] = 1'b0;
            if (step_out === 1'b1) begin
                idx[n] = k;
                lv[n]  = led;
                n++;
            end
        end
        push_btn[0] = 1'b0;
        check("run_pulses", n, 3);
        check("run_led1", lv[0], 8'h01);
        check("run_led2", lv[1], 8'h02);
        check("run_led3", lv[2], 8'h03);
        check("run_gap1", idx[1] - idx[0], CLK_DIV);
        check("run_gap2", idx[2] - idx[1], CLK_DIV);
        check("run_state", state_out, S_RUN);

        // Pause: no further steps
        press(0, 6);
        check("pause_state", state_out, S_PAUSE);
        snap = led;
        c0 = step_cnt;
        repeat (20) cyc();
        check("pause_steps", step_cnt - c0, 0);
        check("pause_led", led, snap);

        // Bounce on step button must be rejected
        c0 = step_cnt;
        snap = led;
        push_btn[1] = 1'b1; cyc(); cyc();
        push_btn[1] = 1'b0; cyc();
        push_btn[1] = 1'b1; cyc(); cyc();
        push_btn[1] = 1'b0;
        repeat (10) cyc();
        check("bounce_steps", step_cnt - c0, 0);
        check("bounce_led", led, snap);

        // Clean 6-cycle hold: exactly one advance
        press(1, 6);
        check("hold_steps", step_cnt - c0, 1);
        check("hold_led", led, snap + 8'd1);

        // Load then single step boundary vectors
        for (int i = 0; i < 6; i++) begin
            mode = vecs[i].mode;
            switch = vecs[i].sw;
            c0 = step_cnt;
            press(2, 6);
            check($sformatf("vec%0d_load_led", i), led, vecs[i].sw);
            check($sformatf("vec%0d_load_nostep", i), step_cnt - c0, 0);
            check($sformatf("vec%0d_load_state", i), state_out, S_PAUSE);
            c0 = step_cnt;
            press(1, 6);
            check($sformatf("vec%0d_step_led", i), led, vecs[i].expect_led);
            check($sformatf("vec%0d_step_cnt", i), step_cnt - c0, 1);
        end

        // Load and run toggle in the same cycle while running
        press(0, 6);
        check("resume_state", state_out, S_RUN);
        mode = 2'b00;
        switch = 8'h5A;
        load_k = -1;
        next_k = -1;
        next_v = 8'h00;
        step_at_load = 1'b1;
        push_btn = 3'b101;
        for (int k = 1; k <= 30 && next_k < 0; k++) begin
            cyc();
            if (k == 6) push_btn = 3'b000;
            if (load_k < 0 && led == 8'h5A) begin
                load_k = k;
                step_at_load = step_out;
            end else if (load_k >= 0 && step_out === 1'b1) begin
                next_k = k;
                next_v = led;
            end
        end
        push_btn = 3'b000;
        check("sim_load_seen", load_k > 0, 1'b1);
        check("sim_load_nostep", step_at_load, 1'b0);
        check("sim_state", state_out, S_RUN);
        check("sim_next_gap", next_k - load_k, CLK_DIV);
        check("sim_next_led", next_v, 8'h5B);

        // Reset mid-count when the prescaler sits at 2
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cyc();
            if (step_out === 1'b1) found = 1;
        end
        check("rst_step_found", found, 1);
        cyc();
        cyc();
        rst_in = 1'b0;
        cyc();
        rst_in = 1'b1;
        check("midrst_led", led, 8'h00);
        check("midrst_state", state_out, S_IDLE);
        check("midrst_step", step_out, 1'b0);
        c0 = step_cnt;
        repeat (30) cyc();
        check("postrst_steps", step_cnt - c0, 0);
        check("postrst_led", led, 8'h00);
        check("postrst_state", state_out, S_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
